// File: rtl/cpu_tx_fifo_pkg.sv
// Shared constants for the CPU-to-host transmit FIFO: I/O select bit indices,
// status-word layout and the output unpacker state encoding.
package cpu_tx_fifo_pkg;

    localparam int OP_W           = 11;
    localparam int SEL_PUSH16_IDX = 0;
    localparam int SEL_PUSH32_IDX = 1;
    localparam int SEL_FLUSH_IDX  = 2;
    localparam int SEL_STATUS_IDX = 3;

    localparam int ENTRY_W   = 33;
    localparam int W32_BIT   = 32;
    localparam int ST_OVFL   = 15;
    localparam int ST_W32    = 13;
    localparam int ST_CNT_W  = 13;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LO    = 2'd1,
        ST_HI    = 2'd2
    } state_t;

    function automatic logic [15:0] status_word(input logic ovfl_bit,
                                                input logic w32_pending,
                                                input logic [ST_CNT_W-1:0] cnt);
        logic [15:0] w;
        w                   = '0;
        w[ST_OVFL]          = ovfl_bit;
        w[ST_W32]           = w32_pending;
        w[ST_CNT_W-1:0]     = cnt;
        return w;
    endfunction

endpackage

// File: rtl/cpu_tx_fifo_mem.sv
// Simple dual-port block RAM: one write port, one registered read port
// (read-before-write on a same-address collision).
module cpu_tx_fifo_mem #(
    parameter int DEPTH_LOG2 = 9,
    parameter int WIDTH      = 33
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem_reg [0:(1<<DEPTH_LOG2)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[waddr] <= wdata;
        end
        rdata <= mem_reg[raddr];
    end

endmodule

// File: rtl/cpu_tx_fifo.sv
// CPU-to-host transmit FIFO with 16/32-bit entries unpacked to a 16-bit FWFT stream.
// Optional macro CPU_TX_FIFO_STATS_EN adds a saturating dropped-push counter.
module cpu_tx_fifo
    import cpu_tx_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = 9,
    parameter int SEL_PUSH16 = SEL_PUSH16_IDX,
    parameter int SEL_PUSH32 = SEL_PUSH32_IDX,
    parameter int SEL_FLUSH  = SEL_FLUSH_IDX,
    parameter int SEL_STATUS = SEL_STATUS_IDX
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_evt,
    input  logic            rd_reg,
    input  logic [OP_W-1:0] op,
    input  logic [31:0]     tos,
    output logic [15:0]     par_dout,
    output logic            par_sel,
    input  logic            h_rd,
    output logic [15:0]     h_dout,
    output logic            h_empty,
    output logic            ovfl
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    logic [DEPTH_LOG2-1:0] wp_reg;
    logic [DEPTH_LOG2-1:0] rp_reg;
    logic [CW-1:0]         mem_cnt_reg;
    logic                  rd_ok_reg;
    state_t                state_reg;
    logic [ENTRY_W-1:0]    head_reg;
    logic                  ovfl_reg;

    logic                  flush;
    logic                  push_req;
    logic                  full;
    logic                  push;
    logic                  drop;
    logic                  retire;
    logic                  load;
    logic [DEPTH_LOG2-1:0] raddr;
    logic [ENTRY_W-1:0]    wdata;
    logic [ENTRY_W-1:0]    rdata;
    logic [CW-1:0]         count;
    logic [15:0]           status;
    logic                  unused_op;

    assign unused_op = ^op;

    assign flush    = wr_evt && op[SEL_FLUSH];
    assign push_req = wr_evt && (op[SEL_PUSH32] || op[SEL_PUSH16]) && !flush;
    assign full     = (mem_cnt_reg == CW'(DEPTH));
    assign push     = push_req && !full;
    assign drop     = push_req && full;
    assign wdata    = op[SEL_PUSH32] ? {1'b1, tos} : {1'b0, 16'h0000, tos[15:0]};

    assign retire = h_rd && (((state_reg == ST_LO) && !head_reg[W32_BIT]) || (state_reg == ST_HI));
    assign load   = rd_ok_reg && ((state_reg == ST_EMPTY) || retire);

    // The read port always looks at the entry that would be loaded next, so a
    // retire can refill the head register in the same edge (1 word/cycle).
    assign raddr = load ? (rp_reg + DEPTH_LOG2'(1)) : rp_reg;

    cpu_tx_fifo_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (ENTRY_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wp_reg),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wp_reg      <= '0;
            rp_reg      <= '0;
            mem_cnt_reg <= '0;
            rd_ok_reg   <= 1'b0;
            state_reg   <= ST_EMPTY;
            head_reg    <= '0;
            ovfl_reg    <= 1'b0;
        end else begin
            if (push) begin
                wp_reg <= wp_reg + DEPTH_LOG2'(1);
            end
            if (load) begin
                rp_reg <= rp_reg + DEPTH_LOG2'(1);
            end
            mem_cnt_reg <= mem_cnt_reg + CW'(push) - CW'(load);
            // Read data is trustworthy only if the addressed entry was already
            // written before this edge (count sampled before the push lands).
            rd_ok_reg <= load ? (mem_cnt_reg > CW'(1)) : (mem_cnt_reg != '0);
            if (drop) begin
                ovfl_reg <= 1'b1;
            end
            case (state_reg)
                ST_EMPTY: begin
                    if (load) begin
                        head_reg  <= rdata;
                        state_reg <= ST_LO;
                    end
                end
                ST_LO: begin
                    if (h_rd) begin
                        if (head_reg[W32_BIT]) begin
                            state_reg <= ST_HI;
                        end else if (load) begin
                            head_reg  <= rdata;
                            state_reg <= ST_LO;
                        end else begin
                            state_reg <= ST_EMPTY;
                        end
                    end
                end
                ST_HI: begin
                    if (h_rd) begin
                        if (load) begin
                            head_reg  <= rdata;
                            state_reg <= ST_LO;
                        end else begin
                            state_reg <= ST_EMPTY;
                        end
                    end
                end
                default: state_reg <= ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        h_dout = 16'h0000;
        case (state_reg)
            ST_LO:   h_dout = head_reg[15:0];
            ST_HI:   h_dout = head_reg[31:16];
            default: h_dout = 16'h0000;
        endcase
    end

    assign h_empty = (state_reg == ST_EMPTY);
    assign ovfl    = ovfl_reg;
    assign count   = mem_cnt_reg + CW'(state_reg != ST_EMPTY);
    assign status  = status_word(ovfl_reg, state_reg == ST_HI, ST_CNT_W'(count));
    assign par_sel = rd_reg && op[SEL_STATUS];

`ifdef CPU_TX_FIFO_STATS_EN
    logic [15:0] drop_cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            drop_cnt_reg <= '0;
        end else if (drop && (drop_cnt_reg != 16'hFFFF)) begin
            drop_cnt_reg <= drop_cnt_reg + 16'd1;
        end
    end

    // Status select together with the flush select is a read of the counter;
    // without wr_evt it never flushes.
    assign par_dout = op[SEL_FLUSH] ? drop_cnt_reg : status;
`else
    assign par_dout = status;
`endif

endmodule

// File: doc/cpu_tx_fifo.md
# cpu_tx_fifo

Buffers data from the embedded stack CPU to the host-side SPI engine. The CPU pushes TOS through its `wrEvt`/`wrEvt2`/`wrEvtL` I/O strobes; the host drains the buffer as a stream of 16-bit words. Fill level and overflow status are returned to the CPU through the `par` read mux on `rdReg`. The block accepts one push per clock, so `wrEvtL` burst loops run at full rate without stalling the CPU.

## Interface
Parameters:
- `DEPTH_LOG2`, 9: entry count is 2^DEPTH_LOG2 entries, each 33 bits (32-bit data plus a width flag).
- `SEL_PUSH16`, 0: `op[]` bit that pushes `tos[15:0]` as a 16-bit entry.
- `SEL_PUSH32`, 1: `op[]` bit that pushes `tos[31:0]` as a 32-bit entry.
- `SEL_FLUSH`, 2: `op[]` bit that empties the FIFO and clears overflow.
- `SEL_STATUS`, 3: `op[]` bit that selects the status word on `rdReg`.

Ports:
- `clk`, in, 1: single clock, shared with the CPU.
- `rst_n`, in, 1: reset, **synchronous, active-low**.
- `wr_evt`, in, 1: OR of the CPU's `wrEvt`, `wrEvt2` and `wrEvtL`.
- `rd_reg`, in, 1: the CPU's `rdReg`.
- `op`, in, 11: the CPU's `op[10:0]` one-hot I/O selects.
- `tos`, in, 32: the CPU's top of stack.
- `par_dout`, out, 16: status word, valid while `par_sel` is high.
- `par_sel`, out, 1: equals `rd_reg && op[SEL_STATUS]`; the block drives the `par` mux.
- `h_rd`, in, 1: host pop of one 16-bit word.
- `h_dout`, out, 16: current head word, first-word-fall-through.
- `h_empty`, out, 1: no host word is available.
- `ovfl`, out, 1: sticky overflow flag.

## Operation
- **Push, on `wr_evt`:**
  - `op[SEL_PUSH32]` takes priority over `op[SEL_PUSH16]`.
  - The entry `{w32, tos}` is written at `wp`, then `wp` increments.
  - A push while full drops the entry and sets `ovfl`. Pointers do not move.
- **Flush, on `wr_evt && op[SEL_FLUSH]`:**
  - Sets `wp = rp = 0`, clears the count and `ovfl`, and empties the output stage.
  - Flush beats a same-cycle push (the push is dropped, `ovfl` is not set) and a same-cycle `h_rd` (ignored).
- **Output unpacker** (FSM states: EMPTY, LO, HI):
  - EMPTY: the head register is invalid.
  - EMPTY → LO: when the memory is non-empty, the head entry is loaded into the output register.
  - LO: `h_dout = data[15:0]`. `h_rd` in LO on a w32 entry → HI. `h_rd` in LO on a 16-bit entry retires the entry → LO with the next entry, or → EMPTY.
  - HI: `h_dout = data[31:16]`. `h_rd` in HI retires the entry → LO or EMPTY.
  - `h_rd` while `h_empty` is ignored.
- **Status word:** `par_dout = {ovfl, 1'b0, w32_pending, count[12:0]}`.
  - `count` is the number of entries in the memory plus the output register (0..2^DEPTH_LOG2+1 max).
  - `w32_pending` is set when the FSM is in HI.
- **Simultaneous push and entry retire:** the count is unchanged, and both pointers advance.
- **Pointer arithmetic:** pointers are DEPTH_LOG2 bits and wrap modulo depth. Full/empty are resolved with the count register, not with the pointers.

## Timing
- **Reset values:** `h_empty` = 1, `h_dout` = 0, `ovfl` = 0, `par_dout` = 0, count = 0, FSM = EMPTY, pointers = 0.
- **Push to host:** a pushed word reaches `h_dout`, with `h_empty` = 0, 2 cycles after the push (BRAM read plus output register) when the FIFO was empty.
- **Host pop:** `h_rd` with `h_empty` = 0 presents the next word on the next cycle. Back-to-back pops are sustained at 1 word/cycle once ≥2 entries are buffered.
- **Status read:** `par_dout` is combinational from registered state, so the CPU latches it on the same `rdReg` edge. A push in cycle N is reflected in the count read at cycle N+1.
- **Mid-operation reset:** a reset asserted mid-operation discards all contents the following cycle.

## Configuration
- Macro: `CPU_TX_FIFO_STATS_EN`.
- **Defined:** adds a 16-bit saturating `drop_cnt` of dropped pushes.
  - `drop_cnt` is cleared by reset and by flush.
  - It is read with `rd_reg && op[SEL_STATUS] && op[SEL_FLUSH]`, which is a read only and does not flush.
  - `par_sel` covers this case.
- **Undefined:** no counter. That select combination returns the normal status word.

## Structure
- **Shared package** (with the CPU's generated I/O constants) holds:
  - the select bit indices;
  - the status-word field positions;
  - the FSM state enum (EMPTY/LO/HI).
- **Sub-module** `cpu_tx_fifo_mem`: simple dual-port BRAM wrapper (2^DEPTH_LOG2 × 33, one write port, one registered read port).
- The top level holds the pointers, count, overflow logic, unpacker FSM and status mux.

## Test plan
1. Push16 0x1234, then push32 0xAABBCCDD. The host pops 3 times and gets 0x1234, 0xCCDD, 0xAABB; then `h_empty` = 1.
2. `wrEvtL`-style 600 consecutive push16 cycles at DEPTH_LOG2 = 9. Required results:
   - the status read shows `ovfl` = 1 and count = 513;
   - host drains 513 words in push order;
   - with STATS, `drop_cnt` = 87.
3. Push and `h_rd` in the same cycle at steady state, count 5. Count stays 5 and data order is preserved across pointer wrap (run 2000 cycles).
4. Flush in the same cycle as a push32 and `h_rd`. Required results: count = 0, `h_empty` = 1 next cycle, `ovfl` = 0, and the pushed word never appears.
5. Pop exactly once on a 32-bit head (state HI). The status shows `w32_pending` = 1. Assert `rst_n` = 0 for 1 cycle: all outputs return to their reset values.
6. `h_rd` while empty, 10 cycles. No state change, count stays 0, `h_dout` = 0.
